lsu_pipe_ctrl: RTL
==================

LSU_PIPE_CTRL -- requirements
Module: lsu_pipe_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width; legal values 32 or 64.
REQ-002 SHALL have parameter RAM_AW, default 14, RAM word-address width.
REQ-003 SHALL have parameter RAM_LAT, default 1, RAM read latency in cycles; legal values 1..4.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 agu_i_valid  in  1  command valid.
REQ-007 agu_o_ready  out  1  command accepted when valid&ready.
REQ-008 agu_i_read, agu_i_write  in  1 each  load / store (one-hot; both or neither = illegal).
REQ-009 agu_i_usign  in  1  zero-extend load.
REQ-010 agu_i_size  in  2  00 byte, 01 half, 10 word, 11 double (XLEN=64 only).
REQ-011 agu_i_addr  in  XLEN  byte address.
REQ-012 agu_i_wdata  in  XLEN  store data, right-aligned.
REQ-013 ram_o_cs, ram_o_we  out  1 each  RAM select / write.
REQ-014 ram_o_wem  out  XLEN/8  byte write enables.
REQ-015 ram_o_addr  out  RAM_AW  word address = agu_i_addr[RAM_AW+B-1:B], B=log2(XLEN/8).
REQ-016 ram_o_wdata  out  XLEN; ram_i_rdata  in  XLEN.
REQ-017 wbck_o_valid  out  1; wbck_i_ready  in  1  response handshake.
REQ-018 wbck_o_wdata  out  XLEN  load result; wbck_o_err  out  1  misaligned/illegal.

Function
REQ-019 FSM states IDLE, REQ, WAIT, WR, RESP; agu_o_ready SHALL equal (state==IDLE); one command outstanding.
REQ-020 On accept (cycle T) command SHALL be registered; later RAM outputs come only from registered command.
REQ-021 Error if addr not aligned to size, size illegal for XLEN, or read/write not one-hot: IDLE->RESP, no ram_o_cs, wbck_o_err=1, wbck_o_wdata=0, valid at T+1.
REQ-022 Load: REQ at T+1 (cs=1, we=0); WAIT RAM_LAT cycles, rdata captured on last WAIT cycle; RESP with valid at T+2+RAM_LAT.
REQ-023 Load result SHALL select lane at offset addr[B-1:0], sign- or zero-extend per agu_i_usign; full-width load unchanged.
REQ-024 Store wdata SHALL be shifted left by 8*offset; lane mask = size bytes starting at offset.
REQ-025 Store response: wbck_o_wdata=0, wbck_o_err=0.
REQ-026 RESP SHALL hold valid, data, err stable until wbck_i_ready; then ->IDLE next cycle.
REQ-027 ram_o_cs/we/wem/wdata SHALL be 0 in every state not performing a RAM access.

Reset
REQ-028 rst SHALL force IDLE, clear registered command, and drive agu_o_ready=1 and every other output 0 in the following cycle.
REQ-029 rst mid-operation SHALL abort: no further RAM access, pending response discarded.

Configuration
REQ-030 Macro LSU_BYTE_WE_EN defined: store REQ at T+1 with cs=1, we=1, wem=lane mask, shifted wdata; RESP valid at T+2.
REQ-031 LSU_BYTE_WE_EN undefined: read-modify-write; REQ reads (we=0), WAIT captures rdata, WR cycle at T+2+RAM_LAT writes wem=all ones, wdata=(shifted data & lane mask)|(rdata & ~lane mask); RESP valid at T+3+RAM_LAT.

Verification (XLEN=32, RAM_LAT=1)
REQ-032 lb addr 0x103, rdata 0x80FF_1234 -> wbck_o_wdata 0xFFFF_FF80, valid at T+3, ram_o_addr 0x40.
REQ-033 lhu addr 0x102, rdata 0x8001_0000 -> 0x0000_8001, err 0.
REQ-034 sb 0xAB addr 0x101: with LSU_BYTE_WE_EN -> T+1 we=1, wem 0010, wdata 0x0000_AB00; without, rdata 0x1122_3344 -> T+3 wdata 0x1122_AB44, wem 1111, valid T+4.
REQ-035 lw addr 0x102 -> valid at T+1, err 1, wdata 0, ram_o_cs never asserted.
REQ-036 load with wbck_i_ready low 3 cycles -> valid/data held stable, agu_o_ready 0 until cycle after handshake.
REQ-037 rst asserted in WAIT -> next cycle state IDLE, all RAM outputs 0, no response issued.

Source files
------------

// File: rtl/lsu_pipe_ctrl_if.sv
// AGU command, RAM port and writeback handshake bundle for lsu_pipe_ctrl.
// master: the side issuing commands, modelling the RAM and consuming responses.
// slave:  the LSU controller.
interface lsu_pipe_ctrl_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned RAM_AW = 14
);
    localparam int unsigned NB = XLEN / 8;

    logic              agu_i_valid;
    logic              agu_o_ready;
    logic              agu_i_read;
    logic              agu_i_write;
    logic              agu_i_usign;
    logic [1:0]        agu_i_size;
    logic [XLEN-1:0]   agu_i_addr;
    logic [XLEN-1:0]   agu_i_wdata;

    logic              ram_o_cs;
    logic              ram_o_we;
    logic [NB-1:0]     ram_o_wem;
    logic [RAM_AW-1:0] ram_o_addr;
    logic [XLEN-1:0]   ram_o_wdata;
    logic [XLEN-1:0]   ram_i_rdata;

    logic              wbck_o_valid;
    logic              wbck_i_ready;
    logic [XLEN-1:0]   wbck_o_wdata;
    logic              wbck_o_err;

    modport master (
        output agu_i_valid, agu_i_read, agu_i_write, agu_i_usign, agu_i_size,
               agu_i_addr, agu_i_wdata, ram_i_rdata, wbck_i_ready,
        input  agu_o_ready, ram_o_cs, ram_o_we, ram_o_wem, ram_o_addr,
               ram_o_wdata, wbck_o_valid, wbck_o_wdata, wbck_o_err
    );

    modport slave (
        input  agu_i_valid, agu_i_read, agu_i_write, agu_i_usign, agu_i_size,
               agu_i_addr, agu_i_wdata, ram_i_rdata, wbck_i_ready,
        output agu_o_ready, ram_o_cs, ram_o_we, ram_o_wem, ram_o_addr,
               ram_o_wdata, wbck_o_valid, wbck_o_wdata, wbck_o_err
    );
endinterface

// File: rtl/lsu_pipe_ctrl.sv
// Single-outstanding load/store controller between the AGU and a word-wide RAM.
// Optional feature macro: LSU_BYTE_WE_EN -- when defined the RAM honours byte
// write enables and stores are one write cycle; otherwise stores are done as
// read-modify-write with a full-word write.
module lsu_pipe_ctrl #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RAM_AW  = 14,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    lsu_pipe_ctrl_if.slave bus
);
    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned B  = $clog2(NB);
    localparam int unsigned CW = 3;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, WR, RESP} state_t;

    typedef struct packed {
        logic              write;
        logic              usign;
        logic              err;
        logic [1:0]        size;
        logic [B-1:0]      off;
        logic [RAM_AW-1:0] waddr;
        logic [XLEN-1:0]   wdata;
    } cmd_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    cmd_t              cmd_q, cmd_d;

    logic              ram_cs_q, ram_cs_d;
    logic              ram_we_q, ram_we_d;
    logic [NB-1:0]     ram_wem_q, ram_wem_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [XLEN-1:0]   ram_wdata_q, ram_wdata_d;
    logic              wbck_valid_q, wbck_valid_d;
    logic [XLEN-1:0]   wbck_wdata_q, wbck_wdata_d;
    logic              wbck_err_q, wbck_err_d;

    logic              misalign;
    logic              in_err;
    logic [7:0]        base_mask;
    logic [NB-1:0]     lane_mask;
    logic [XLEN-1:0]   bit_mask;
    logic [XLEN-1:0]   st_data;
    logic [XLEN-1:0]   ld_sh;
    logic [XLEN-1:0]   ld_data;
    logic              unused_addr_hi;

    // Address bits above the RAM window carry no meaning here
    assign unused_addr_hi = ^bus.agu_i_addr[XLEN-1:RAM_AW+B];

    // Reject misaligned, oversize or non-one-hot commands before they reach RAM
    always_comb begin
        misalign = 1'b0;
        case (bus.agu_i_size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = bus.agu_i_addr[0];
            2'b10:   misalign = (bus.agu_i_addr[1:0] != 2'b00);
            default: misalign = (XLEN == 32) ? 1'b1 : (bus.agu_i_addr[2:0] != 3'b000);
        endcase
        in_err = misalign | ~(bus.agu_i_read ^ bus.agu_i_write);
    end

    // Lane mask, store alignment and load extraction for the in-flight command
    always_comb begin
        case (cmd_d.size)
            2'b00:   base_mask = 8'h01;
            2'b01:   base_mask = 8'h03;
            2'b10:   base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
        lane_mask = NB'(base_mask << cmd_d.off);
        for (int i = 0; i < NB; i++) begin
            bit_mask[8*i +: 8] = {8{lane_mask[i]}};
        end
        st_data = cmd_d.wdata << {cmd_d.off, 3'b000};
        ld_sh   = bus.ram_i_rdata >> {cmd_d.off, 3'b000};
        case (cmd_d.size)
            2'b00:   ld_data = cmd_d.usign ? XLEN'(ld_sh[7:0])  : XLEN'($signed(ld_sh[7:0]));
            2'b01:   ld_data = cmd_d.usign ? XLEN'(ld_sh[15:0]) : XLEN'($signed(ld_sh[15:0]));
            2'b10:   ld_data = cmd_d.usign ? XLEN'(ld_sh[31:0]) : XLEN'($signed(ld_sh[31:0]));
            default: ld_data = ld_sh;
        endcase
    end

    // Next state, command capture and next values of the registered outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmd_d        = cmd_q;
        ram_cs_d     = 1'b0;
        ram_we_d     = 1'b0;
        ram_wem_d    = '0;
        ram_addr_d   = '0;
        ram_wdata_d  = '0;
        wbck_valid_d = 1'b0;
        wbck_wdata_d = '0;
        wbck_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.agu_i_valid) begin
                    cmd_d.write = bus.agu_i_write;
                    cmd_d.usign = bus.agu_i_usign;
                    cmd_d.err   = in_err;
                    cmd_d.size  = bus.agu_i_size;
                    cmd_d.off   = bus.agu_i_addr[B-1:0];
                    cmd_d.waddr = bus.agu_i_addr[RAM_AW+B-1:B];
                    cmd_d.wdata = bus.agu_i_wdata;
                    state_d     = in_err ? RESP : REQ;
                end
            end
            REQ: begin
                cnt_d = '0;
`ifdef LSU_BYTE_WE_EN
                state_d = cmd_q.write ? RESP : WAIT;
`else
                state_d = WAIT;
`endif
            end
            WAIT: begin
                if (cnt_q == CW'(RAM_LAT - 1)) begin
`ifdef LSU_BYTE_WE_EN
                    state_d = RESP;
`else
                    state_d = cmd_q.write ? WR : RESP;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WR:      state_d = RESP;
            RESP:    if (bus.wbck_i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        case (state_d)
            REQ: begin
                ram_cs_d   = 1'b1;
                ram_addr_d = cmd_d.waddr;
`ifdef LSU_BYTE_WE_EN
                if (cmd_d.write) begin
                    ram_we_d    = 1'b1;
                    ram_wem_d   = lane_mask;
                    ram_wdata_d = st_data;
                end
`endif
            end
            WR: begin
                ram_cs_d    = 1'b1;
                ram_we_d    = 1'b1;
                ram_wem_d   = '1;
                ram_addr_d  = cmd_d.waddr;
                ram_wdata_d = (st_data & bit_mask) | (bus.ram_i_rdata & ~bit_mask);
            end
            RESP: begin
                if (state_q == RESP) begin
                    wbck_valid_d = wbck_valid_q;
                    wbck_wdata_d = wbck_wdata_q;
                    wbck_err_d   = wbck_err_q;
                end else begin
                    wbck_valid_d = 1'b1;
                    wbck_err_d   = cmd_d.err;
                    wbck_wdata_d = (cmd_d.err || cmd_d.write) ? '0 : ld_data;
                end
            end
            default: ;
        endcase
    end

    // State, command and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cmd_q        <= '0;
            ram_cs_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_wem_q    <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            wbck_valid_q <= 1'b0;
            wbck_wdata_q <= '0;
            wbck_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_q        <= cmd_d;
            ram_cs_q     <= ram_cs_d;
            ram_we_q     <= ram_we_d;
            ram_wem_q    <= ram_wem_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            wbck_valid_q <= wbck_valid_d;
            wbck_wdata_q <= wbck_wdata_d;
            wbck_err_q   <= wbck_err_d;
        end
    end

    assign bus.agu_o_ready  = (state_q == IDLE);
    assign bus.ram_o_cs     = ram_cs_q;
    assign bus.ram_o_we     = ram_we_q;
    assign bus.ram_o_wem    = ram_wem_q;
    assign bus.ram_o_addr   = ram_addr_q;
    assign bus.ram_o_wdata  = ram_wdata_q;
    assign bus.wbck_o_valid = wbck_valid_q;
    assign bus.wbck_o_wdata = wbck_wdata_q;
    assign bus.wbck_o_err   = wbck_err_q;
endmodule
